// File: rtl/seq_run_pkg.sv
// rtl/seq_run_pkg.sv - state layout and mode constants for the run detector
package seq_run_pkg;

  localparam int IDLE_IDX  = 0;
  localparam int ZERO_BASE = 0;

  localparam logic MODE_OVL    = 1'b0;
  localparam logic MODE_NONOVL = 1'b1;

  // Bit ZERO_BASE+k holds a run of k zeros; bit one_base(RUN_LEN)+k a run of k ones.
  function automatic int one_base(input int run_len);
    return ZERO_BASE + run_len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int width = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             clr,
  input  logic             inc,
  output logic [width-1:0] count
);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_run_detector.sv
// rtl/seq_run_detector.sv - one-hot run-of-equal-bits detector with event counter
module seq_run_detector
  import seq_run_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               en,
  input  logic               w,
  input  logic               mode_nonovl,
  input  logic               cnt_clr,
  output logic               z,
  output logic               z_zero,
  output logic               z_one,
  output logic [2*RUN_LEN:0] state_oh,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int NS       = 2 * RUN_LEN + 1;
  localparam int ONE_BASE = one_base(RUN_LEN);
  localparam int ZK       = ZERO_BASE + RUN_LEN;
  localparam int OK       = ONE_BASE + RUN_LEN;

  logic [NS-1:0]      state_q;
  logic [NS-1:0]      state_nxt;
  logic [RUN_LEN-1:0] zrun;
  logic [RUN_LEN-1:0] orun;
  logic [RUN_LEN-1:0] znext;
  logic [RUN_LEN-1:0] onext;
  logic               legal;
  logic               hit;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= NS'(1) << IDLE_IDX;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    zrun      = state_q[ZK:ZERO_BASE+1];
    orun      = state_q[OK:ONE_BASE+1];
    legal     = (state_q != '0) && ((state_q & (state_q - 1'b1)) == '0);
    znext     = '0;
    onext     = '0;
    state_nxt = '0;
    if (!legal) begin
      state_nxt[IDLE_IDX] = 1'b1;
    end else if (!en) begin
      state_nxt = state_q;
    end else if (w == 1'b0) begin
      // Runs shift up one position; the top position either holds or restarts.
      znext                = {zrun[RUN_LEN-2:0], 1'b0};
      znext[RUN_LEN-1]    |= zrun[RUN_LEN-1] & (mode_nonovl == MODE_OVL);
      znext[0]             = state_q[IDLE_IDX] | (|orun)
                           | (zrun[RUN_LEN-1] & (mode_nonovl == MODE_NONOVL));
      state_nxt[ZK:ZERO_BASE+1] = znext;
    end else begin
      onext                = {orun[RUN_LEN-2:0], 1'b0};
      onext[RUN_LEN-1]    |= orun[RUN_LEN-1] & (mode_nonovl == MODE_OVL);
      onext[0]             = state_q[IDLE_IDX] | (|zrun)
                           | (orun[RUN_LEN-1] & (mode_nonovl == MODE_NONOVL));
      state_nxt[OK:ONE_BASE+1] = onext;
    end
  end

  always_comb begin
    z_zero   = state_q[ZK];
    z_one    = state_q[OK];
    z        = z_zero | z_one;
    state_oh = state_q;
    hit      = (state_nxt[ZK] & ~state_q[ZK]) | (state_nxt[OK] & ~state_q[OK]);
  end

  sat_counter #(
    .width(CNT_W)
  ) u_cnt (
    .Clock(Clock),
    .Reset(Reset),
    .clr  (cnt_clr),
    .inc  (hit),
    .count(match_cnt)
  );

endmodule

// File: tb/tb_seq_run_detector.sv
// tb/tb_seq_run_detector.sv - bench for seq_run_detector
module tb_seq_run_detector;

  localparam int RL = 4;
  localparam int NS = 2 * RL + 1;

  logic clk = 1'b0;
  logic rst, en, w, mode, clr;
  logic z1, zz1, zo1, z2, zz2, zo2;
  logic [NS-1:0] st1, st2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_run_detector #(.RUN_LEN(RL), .CNT_W(8)) dut1 (
    .Clock(clk), .Reset(rst), .en(en), .w(w), .mode_nonovl(mode), .cnt_clr(clr),
    .z(z1), .z_zero(zz1), .z_one(zo1), .state_oh(st1), .match_cnt(cnt1)
  );

  seq_run_detector #(.RUN_LEN(RL), .CNT_W(2)) dut2 (
    .Clock(clk), .Reset(rst), .en(en), .w(w), .mode_nonovl(mode), .cnt_clr(clr),
    .z(z2), .z_zero(zz2), .z_one(zo2), .state_oh(st2), .match_cnt(cnt2)
  );

  typedef struct {
    logic r, e, wi, m, c;
    logic [NS-1:0] st;
    logic zz, zo;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, e, wi, m, c, input logic [NS-1:0] st,
                     input logic zz, zo, input logic [7:0] cnt);
    vec_t v;
    v.r = r; v.e = e; v.wi = wi; v.m = m; v.c = c;
    v.st = st; v.zz = zz; v.zo = zo; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, e, wi, m, c);
    @(negedge clk);
    rst = r; en = e; w = wi; mode = m; clr = c;
    @(posedge clk);
    #1;
  endtask

  // Reference model: current run as (value, length), length 0 meaning idle.
  int   m_len = 0;
  logic m_val = 1'b0;
  int   m_c1 = 0;
  int   m_c2 = 0;

  task automatic model_step(input logic r, e, wi, m, c);
    int   nl;
    logic nv;
    bit   ev;
    if (r) begin
      m_len = 0; m_c1 = 0; m_c2 = 0;
    end else begin
      nl = m_len;
      nv = m_val;
      if (e) begin
        if (m_len > 0 && wi == m_val) nl = (m_len < RL) ? m_len + 1 : (m ? 1 : RL);
        else begin nl = 1; nv = wi; end
      end
      ev = (nl == RL) && !(m_len == RL && m_val == nv);
      if (c) begin
        m_c1 = 0; m_c2 = 0;
      end else if (ev) begin
        m_c1 = (m_c1 < 255) ? m_c1 + 1 : 255;
        m_c2 = (m_c2 < 3) ? m_c2 + 1 : 3;
      end
      m_len = nl;
      m_val = nv;
    end
  endtask

  function automatic logic [NS-1:0] exp_state();
    if (m_len == 0) return NS'(1);
    return NS'(1) << (m_val ? RL + m_len : m_len);
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; w = 1'b0; mode = 1'b0; clr = 1'b0;

    // run of zeros, overlapping
    add(1,0,0,0,0, 9'h001,0,0,0);
    add(0,1,0,0,0, 9'h002,0,0,0);
    add(0,1,0,0,0, 9'h004,0,0,0);
    add(0,1,0,0,0, 9'h008,0,0,0);
    add(0,1,0,0,0, 9'h010,1,0,1);
    add(0,1,0,0,0, 9'h010,1,0,1);
    add(0,1,1,0,0, 9'h020,0,0,1);
    // enable gap mid-run
    add(1,0,0,0,0, 9'h001,0,0,0);
    add(0,1,1,0,0, 9'h020,0,0,0);
    add(0,1,1,0,0, 9'h040,0,0,0);
    add(0,0,0,0,0, 9'h040,0,0,0);
    add(0,0,1,0,0, 9'h040,0,0,0);
    add(0,0,0,0,0, 9'h040,0,0,0);
    add(0,1,1,0,0, 9'h080,0,0,0);
    add(0,1,1,0,0, 9'h100,0,1,1);
    // non-overlapping ones
    add(1,0,0,0,0, 9'h001,0,0,0);
    add(0,1,1,1,0, 9'h020,0,0,0);
    add(0,1,1,1,0, 9'h040,0,0,0);
    add(0,1,1,1,0, 9'h080,0,0,0);
    add(0,1,1,1,0, 9'h100,0,1,1);
    add(0,1,1,1,0, 9'h020,0,0,1);
    add(0,1,1,1,0, 9'h040,0,0,1);
    add(0,1,1,1,0, 9'h080,0,0,1);
    add(0,1,1,1,0, 9'h100,0,1,2);
    add(0,0,1,1,1, 9'h100,0,1,0);
    // mid-run reset, then mode change at full run
    add(1,0,0,0,0, 9'h001,0,0,0);
    add(0,1,0,0,0, 9'h002,0,0,0);
    add(0,1,0,0,0, 9'h004,0,0,0);
    add(0,1,0,0,0, 9'h008,0,0,0);
    add(1,1,0,0,0, 9'h001,0,0,0);
    add(0,1,0,0,0, 9'h002,0,0,0);
    add(0,1,0,0,0, 9'h004,0,0,0);
    add(0,1,0,0,0, 9'h008,0,0,0);
    add(0,1,0,0,0, 9'h010,1,0,1);
    add(0,1,0,1,0, 9'h002,0,0,1);

    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].e, vecs[i].wi, vecs[i].m, vecs[i].c);
      check($sformatf("vec%0d.state", i), 32'(st1), 32'(vecs[i].st));
      check($sformatf("vec%0d.z_zero", i), 32'(zz1), 32'(vecs[i].zz));
      check($sformatf("vec%0d.z_one", i), 32'(zo1), 32'(vecs[i].zo));
      check($sformatf("vec%0d.z", i), 32'(z1), 32'(vecs[i].zz | vecs[i].zo));
      check($sformatf("vec%0d.cnt", i), 32'(cnt1), 32'(vecs[i].cnt));
    end

    // five separate events saturate a 2-bit counter; clear beats a coincident event
    apply(1,0,0,0,0);
    for (int e = 0; e < 5; e++) begin
      for (int b = 0; b < RL; b++) apply(0, 1, 1'(e % 2), 0, 0);
      check($sformatf("sat.ev%0d", e), 32'(cnt2), (e < 2) ? 32'(e + 1) : 32'd3);
    end
    check("sat.wide_cnt", 32'(cnt1), 32'd5);
    for (int b = 0; b < RL - 1; b++) apply(0, 1, 1, 0, 0);
    apply(0, 1, 1, 0, 1);
    check("sat.clr_vs_event", 32'(cnt2), 32'd0);
    check("sat.clr_vs_event_state", 32'(zo2), 32'd1);

    // illegal state recovery
    apply(1,0,0,0,0);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; w = 1'b1;
    force dut1.state_q = 9'b000010001;
    #1;
    check("illegal.multi", 32'(dut1.state_nxt), 32'd1);
    en = 1'b0;
    force dut1.state_q = 9'b000000000;
    #1;
    check("illegal.zero", 32'(dut1.state_nxt), 32'd1);
    release dut1.state_q;
    @(posedge clk);
    #1;
    check("illegal.recover", 32'(st1), 32'd1);

    // randomized run against the model
    apply(1,0,0,0,0);
    model_step(1,0,0,0,0);
    for (int n = 0; n < 3000; n++) begin
      logic r, e, wi, m, c;
      r  = ($urandom_range(0, 149) == 0);
      e  = ($urandom_range(0, 3) != 0);
      wi = ($urandom_range(0, 3) == 0) ? ~w : w;
      m  = ($urandom_range(0, 19) == 0) ? ~mode : mode;
      c  = ($urandom_range(0, 59) == 0);
      apply(r, e, wi, m, c);
      model_step(r, e, wi, m, c);
      check($sformatf("rnd%0d.state", n), 32'(st1), 32'(exp_state()));
      check($sformatf("rnd%0d.z", n), 32'(z1), 32'(m_len == RL));
      check($sformatf("rnd%0d.z_zero", n), 32'(zz1), 32'(m_len == RL && !m_val));
      check($sformatf("rnd%0d.z_one", n), 32'(zo1), 32'(m_len == RL && m_val));
      check($sformatf("rnd%0d.cnt8", n), 32'(cnt1), 32'(m_c1));
      check($sformatf("rnd%0d.state2", n), 32'(st2), 32'(exp_state()));
      check($sformatf("rnd%0d.z2", n), 32'(z2), 32'(zz2 | zo2));
      check($sformatf("rnd%0d.cnt2", n), 32'(cnt2), 32'(m_c2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
